// File: rtl/detour_sign_scheduler_pkg.sv
// Shared types and constants for the detour-sign scheduler.
// State encodings, direction codes and the round-robin pick.
package detour_sign_scheduler_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int         FRAMES_PER_SWEEP = 4;
  localparam logic [1:0] FRAME_LAST =
    2'(FRAMES_PER_SWEEP - 1);

  // A tie goes to the side that was not served last.
  function automatic logic pick_left(
    input logic pl,
    input logic pr,
    input logic last
  );
    return pl & (~pr | (last == DIR_RIGHT));
  endfunction

endpackage

// File: rtl/detour_sign_scheduler_step_timer.sv
// Frame prescaler for the detour-sign scheduler.
// Counts 0..STEP_CYCLES-1 while enabled; o_tc marks the last count.
module detour_sign_scheduler_step_timer #(
  parameter int STEP_CYCLES = 4,
  parameter int CNT_W       = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LP_TC =
    CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LP_TC) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == LP_TC);

endmodule

// File: rtl/detour_sign_scheduler.sv
// Detour-sign job scheduler: round-robin left/right arbitration,
// depth-1 request queues, and step pacing of the sign sequencer.
module detour_sign_scheduler
  import detour_sign_scheduler_pkg::*;
#(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int SWEEPS      = 4,
  parameter int CNT_W       = 25,
  parameter int SW_W        = 3
) (
  input  logic            Clk,
  input  logic            reset_n,
  input  logic            req_left,
  input  logic            req_right,
  input  logic            cancel,
  output logic            sm_step,
  output logic            L_Rbar,
  output logic            busy,
  output logic            grant_left,
  output logic            grant_right,
  output logic            pend_left,
  output logic            pend_right,
  output logic [SW_W-1:0] sweep_cnt
);

  localparam logic [SW_W-1:0] LP_LAST =
    SW_W'(SWEEPS - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_pend_l;
  logic            r_pend_r;
  logic            r_last;
  logic            r_dir;
  logic            r_grant_l;
  logic            r_grant_r;
  logic            r_abort;
  logic [1:0]      r_frame;
  logic [SW_W-1:0] r_sweep;

  logic w_tc;
  logic w_run;
  logic w_step;
  logic w_wrap;
  logic w_start;
  logic w_pick_l;

  assign w_run = (r_state == S_RUN);

  detour_sign_scheduler_step_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .i_clk   (Clk),
    .i_rst_n (reset_n),
    .i_clr   (w_start),
    .i_en    (w_run),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_pick_l    = pick_left(r_pend_l, r_pend_r, r_last);
    w_step      = w_run & w_tc;
    w_wrap      = w_step & (r_frame == FRAME_LAST);
    unique case (r_state)
      S_IDLE: begin
        if (r_pend_l || r_pend_r) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
        end
      end
      S_RUN: begin
        // Only a sweep boundary may end a job.
        if (w_wrap && (r_sweep == LP_LAST || r_abort)) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pend_l  <= 1'b0;
      r_pend_r  <= 1'b0;
      r_last    <= DIR_RIGHT;
      r_dir     <= 1'b0;
      r_grant_l <= 1'b0;
      r_grant_r <= 1'b0;
      r_abort   <= 1'b0;
      r_frame   <= '0;
      r_sweep   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant_l <= w_start & w_pick_l;
      r_grant_r <= w_start & ~w_pick_l;
      if (req_left) begin
        r_pend_l <= 1'b1;
      end else if (w_start && w_pick_l) begin
        r_pend_l <= 1'b0;
      end
      if (req_right) begin
        r_pend_r <= 1'b1;
      end else if (w_start && !w_pick_l) begin
        r_pend_r <= 1'b0;
      end
      if (w_start) begin
        r_dir   <= w_pick_l ? DIR_LEFT : DIR_RIGHT;
        r_last  <= w_pick_l ? DIR_LEFT : DIR_RIGHT;
        r_abort <= 1'b0;
        r_frame <= '0;
        r_sweep <= '0;
      end else begin
        if (w_run && cancel) begin
          r_abort <= 1'b1;
        end
        if (w_step) begin
          r_frame <= r_frame + 1'b1;
        end
        if (w_wrap) begin
          r_sweep <= r_sweep + 1'b1;
        end
      end
    end
  end

  assign sm_step     = w_step;
  assign L_Rbar      = r_dir;
  assign busy        = w_run;
  assign grant_left  = r_grant_l;
  assign grant_right = r_grant_r;
  assign pend_left   = r_pend_l;
  assign pend_right  = r_pend_r;
  assign sweep_cnt   = r_sweep;

endmodule

// File: tb/tb_detour_sign_scheduler.sv
// Directed bench for detour_sign_scheduler (STEP_CYCLES=4, SWEEPS=2).
// Expected grants/steps are queued at stimulus time and popped on output.
module tb_detour_sign_scheduler;

  localparam int STEP   = 4;
  localparam int SWEEPS = 2;
  localparam int SW_W   = 2;

  logic            Clk;
  logic            reset_n;
  logic            req_left;
  logic            req_right;
  logic            cancel;
  logic            sm_step;
  logic            L_Rbar;
  logic            busy;
  logic            grant_left;
  logic            grant_right;
  logic            pend_left;
  logic            pend_right;
  logic [SW_W-1:0] sweep_cnt;

  detour_sign_scheduler #(
    .STEP_CYCLES (STEP),
    .SWEEPS      (SWEEPS),
    .CNT_W       (2),
    .SW_W        (SW_W)
  ) dut (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .req_left    (req_left),
    .req_right   (req_right),
    .cancel      (cancel),
    .sm_step     (sm_step),
    .L_Rbar      (L_Rbar),
    .busy        (busy),
    .grant_left  (grant_left),
    .grant_right (grant_right),
    .pend_left   (pend_left),
    .pend_right  (pend_right),
    .sweep_cnt   (sweep_cnt)
  );

  typedef struct {
    int   cyc;
    logic left;
  } grant_t;

  int     exp_step[$];
  grant_t exp_grant[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     cyc;
  logic   prev_busy = 1'b0;
  logic   prev_lr = 1'b0;
  grant_t g;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) cyc <= -1;
    else          cyc <= cyc + 1;
  end

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d",
             tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops plus running invariants.
  always @(negedge Clk) begin
    if (reset_n) begin
      if (sm_step) begin
        check("step_busy", busy, 1);
        if (exp_step.size() == 0)
          check("step_spurious", sm_step, 0);
        else
          check("step_cycle", cyc, exp_step.pop_front());
      end
      if (busy && prev_busy)
        check("lrbar_stable", L_Rbar, prev_lr);
      if (grant_left || grant_right) begin
        check("grant_idle_before", prev_busy, 0);
        check("grant_onehot", grant_left & grant_right, 0);
        if (exp_grant.size() == 0) begin
          check("grant_spurious", 1, 0);
        end else begin
          g = exp_grant.pop_front();
          check("grant_cycle", cyc, g.cyc);
          check("grant_side", grant_left, g.left);
          check("grant_lrbar", L_Rbar, g.left);
        end
      end
      prev_busy = busy;
      prev_lr   = L_Rbar;
    end else begin
      prev_busy = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_to(int c);
    int n = 0;
    while (cyc < c && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    if (cyc != c) check("sync", cyc, c);
  endtask

  task automatic drive_req(int c, logic l, logic r);
    tick_to(c);
    req_left  = l;
    req_right = r;
    @(negedge Clk);
    req_left  = 1'b0;
    req_right = 1'b0;
  endtask

  task automatic push_job(int gc, logic left, int nsteps);
    exp_grant.push_back('{gc, left});
    for (int k = 0; k < nsteps; k++)
      exp_step.push_back(gc + STEP * (k + 1) - 1);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    reset_n   = 1'b0;
    req_left  = 1'b0;
    req_right = 1'b0;
    cancel    = 1'b0;
    exp_step.delete();
    exp_grant.delete();
    @(negedge Clk);
    @(negedge Clk);
    reset_n = 1'b1;
  endtask

  task automatic chk_idle(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_step"}, sm_step, 0);
    check({tag, "_gl"}, grant_left, 0);
    check({tag, "_gr"}, grant_right, 0);
    check({tag, "_pl"}, pend_left, 0);
    check({tag, "_pr"}, pend_right, 0);
  endtask

  task automatic chk_drained(string tag);
    check(tag, exp_step.size() + exp_grant.size(), 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_left  = 1'b0;
    req_right = 1'b0;
    cancel    = 1'b0;
    repeat (3) @(negedge Clk);
    chk_idle("rst");
    check("rst_lrbar", L_Rbar, 0);
    check("rst_sweep", sweep_cnt, 0);
    reset_n = 1'b1;

    // Single left job
    push_job(12, 1'b1, 4 * SWEEPS);
    drive_req(10, 1'b1, 1'b0);
    check("t1_pend", pend_left, 1);
    tick_to(12);
    check("t1_busy", busy, 1);
    check("t1_lrbar", L_Rbar, 1);
    check("t1_pend_clr", pend_left, 0);
    tick_to(27); check("t1_sw0", sweep_cnt, 0);
    tick_to(28); check("t1_sw1", sweep_cnt, 1);
    tick_to(43); check("t1_busy43", busy, 1);
    tick_to(44);
    check("t1_done", busy, 0);
    check("t1_sw2", sweep_cnt, 2);
    tick_to(50); chk_drained("t1_drained");

    // Simultaneous requests after reset: left wins the tie
    do_reset();
    push_job(7, 1'b1, 4 * SWEEPS);
    push_job(40, 1'b0, 4 * SWEEPS);
    drive_req(5, 1'b1, 1'b1);
    check("t2_pl", pend_left, 1);
    check("t2_pr", pend_right, 1);
    tick_to(7);
    check("t2_pl_clr", pend_left, 0);
    check("t2_pr_hold", pend_right, 1);
    tick_to(39);
    check("t2_gap", busy, 0);
    check("t2_lr_hold", L_Rbar, 1);
    tick_to(40);
    check("t2_lr", L_Rbar, 0);
    check("t2_pr_clr", pend_right, 0);
    tick_to(72); check("t2_done", busy, 0);
    tick_to(75); chk_drained("t2_drained");

    // Repeated right requests collapse into one extra job
    push_job(82, 1'b0, 4 * SWEEPS);
    push_job(115, 1'b0, 4 * SWEEPS);
    drive_req(80, 1'b0, 1'b1);
    drive_req(85, 1'b0, 1'b1);
    check("t3_pr", pend_right, 1);
    drive_req(90, 1'b0, 1'b1);
    drive_req(95, 1'b0, 1'b1);
    check("t3_pl", pend_left, 0);
    tick_to(114); check("t3_pr114", pend_right, 1);
    tick_to(148);
    check("t3_done", busy, 0);
    check("t3_pr_empty", pend_right, 0);

    // Both sides kept pending: grants alternate
    push_job(152, 1'b1, 4 * SWEEPS);
    push_job(185, 1'b0, 4 * SWEEPS);
    push_job(218, 1'b1, 4 * SWEEPS);
    push_job(251, 1'b0, 4 * SWEEPS);
    drive_req(150, 1'b1, 1'b1);
    drive_req(190, 1'b1, 1'b1);
    check("t3_both_l", pend_left, 1);
    check("t3_both_r", pend_right, 1);
    tick_to(284);
    check("t3_alt_done", busy, 0);
    check("t3_alt_pl", pend_left, 0);
    check("t3_alt_pr", pend_right, 0);
    chk_drained("t3_drained");

    // Cancel mid-sweep finishes the sweep
    do_reset();
    push_job(7, 1'b1, 4);
    drive_req(5, 1'b1, 1'b0);
    tick_to(12);
    cancel = 1'b1;
    @(negedge Clk);
    cancel = 1'b0;
    tick_to(22); check("t4_busy22", busy, 1);
    tick_to(23);
    check("t4_done", busy, 0);
    check("t4_sw", sweep_cnt, 1);

    // Cancel in IDLE is ignored and keeps the pend flag
    push_job(32, 1'b0, 4 * SWEEPS);
    tick_to(30);
    req_right = 1'b1;
    cancel    = 1'b1;
    @(negedge Clk);
    req_right = 1'b0;
    check("t4_pr_kept", pend_right, 1);
    @(negedge Clk);
    cancel = 1'b0;
    check("t4_run", busy, 1);
    // Cancel on the final sweep changes nothing
    tick_to(50);
    cancel = 1'b1;
    @(negedge Clk);
    cancel = 1'b0;
    tick_to(63);
    check("t4_busy63", busy, 1);
    check("t4_sw63", sweep_cnt, 1);
    tick_to(64);
    check("t4_done2", busy, 0);
    check("t4_sw2", sweep_cnt, 2);
    tick_to(68); chk_drained("t4_drained");

    // Asynchronous reset mid-job
    do_reset();
    push_job(7, 1'b1, 5);
    drive_req(5, 1'b1, 1'b0);
    drive_req(20, 1'b0, 1'b1);
    check("t5_pr", pend_right, 1);
    tick_to(29);
    @(posedge Clk);
    #1;
    check("t5_step6", sm_step, 1);
    reset_n = 1'b0;
    #1;
    chk_idle("t5_async");
    check("t5_sweep", sweep_cnt, 0);
    chk_drained("t5_drained");
    @(negedge Clk);
    @(negedge Clk);
    reset_n = 1'b1;
    tick_to(20);
    chk_idle("t5_after");
    chk_drained("t5_quiet");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
